// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, phase-state type and saturation limits for the FIR serializer
package fir_pkg;

    localparam int IN_W_DEF  = 64;
    localparam int OUT_W_DEF = 16;

    localparam logic signed [OUT_W_DEF-1:0] SAT_MAX_DEF = {1'b0, {(OUT_W_DEF-1){1'b1}}};
    localparam logic signed [OUT_W_DEF-1:0] SAT_MIN_DEF = {1'b1, {(OUT_W_DEF-1){1'b0}}};

    typedef enum logic [1:0] {
        EMIT0 = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } phase_e;

endpackage

// File: rtl/fir_requant.sv
// rtl/fir_requant.sv - round-half-up, arithmetic shift and saturate one FIR phase output
module fir_requant
    import fir_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 15
) (
    input  logic signed [IN_W-1:0]  in_data,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat
);

    localparam logic [IN_W:0] ONE = {{IN_W{1'b0}}, 1'b1};
    localparam int            RS  = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic signed [IN_W:0] RND  = (SHIFT > 0) ? $signed(ONE << RS) : '0;
    localparam logic signed [IN_W:0] MAXV = $signed((ONE << (OUT_W - 1)) - ONE);
    localparam logic signed [IN_W:0] MINV = ~MAXV;

    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shifted;

    // One guard bit keeps the rounding add from wrapping near the positive limit.
    always_comb begin
        ext      = {in_data[IN_W-1], in_data};
        sum      = ext + RND;
        shifted  = sum >>> SHIFT;
        out_sat  = 1'b0;
        out_data = shifted[OUT_W-1:0];
        if (shifted > MAXV) begin
            out_sat  = 1'b1;
            out_data = MAXV[OUT_W-1:0];
        end else if (shifted < MINV) begin
            out_sat  = 1'b1;
            out_data = MINV[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/fir_par3_serializer.sv
// rtl/fir_par3_serializer.sv - buffers requantized 3-phase FIR triples and emits them as a serial stream
module fir_par3_serializer
    import fir_pkg::*;
#(
    parameter int IN_W  = IN_W_DEF,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_p0,
    input  logic signed [IN_W-1:0]  in_p1,
    input  logic signed [IN_W-1:0]  in_p2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_sat,
    output logic [15:0]             sat_count
);

    logic signed [IN_W-1:0]  in_ph  [3];
    logic signed [OUT_W-1:0] rq_data[3];
    logic [2:0]              rq_sat;

    assign in_ph[0] = in_p0;
    assign in_ph[1] = in_p1;
    assign in_ph[2] = in_p2;

    for (genvar g = 0; g < 3; g++) begin : g_requant
        fir_requant #(
            .IN_W  (IN_W),
            .OUT_W (OUT_W),
            .SHIFT (SHIFT)
        ) u_requant (
            .in_data  (in_ph[g]),
            .out_data (rq_data[g]),
            .out_sat  (rq_sat[g])
        );
    end

    logic [OUT_W-1:0] mem_data_q [2][3];
    logic [OUT_W-1:0] mem_data_d [2][3];
    logic [2:0]       mem_sat_q  [2];
    logic [2:0]       mem_sat_d  [2];

    logic [1:0]  count_q, count_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    phase_e      phase_q, phase_d;
    logic [15:0] sat_count_q, sat_count_d;

    logic             push;
    logic             pop;
    logic             out_xfer;
    logic [OUT_W-1:0] head_data;
    logic             head_sat;

    assign in_ready  = (count_q < 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign out_xfer  = out_valid && out_ready;
    assign pop       = out_xfer && (phase_q == EMIT2);

    always_comb begin
        head_data = '0;
        head_sat  = 1'b0;
        case (phase_q)
            EMIT0:   begin head_data = mem_data_q[rd_ptr_q][0]; head_sat = mem_sat_q[rd_ptr_q][0]; end
            EMIT1:   begin head_data = mem_data_q[rd_ptr_q][1]; head_sat = mem_sat_q[rd_ptr_q][1]; end
            EMIT2:   begin head_data = mem_data_q[rd_ptr_q][2]; head_sat = mem_sat_q[rd_ptr_q][2]; end
            default: begin head_data = '0; head_sat = 1'b0; end
        endcase
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign out_data  = out_valid ? $signed(head_data) : '0;
    assign out_sat   = out_valid && head_sat;
    assign sat_count = sat_count_q;

    always_comb begin
        mem_data_d = mem_data_q;
        mem_sat_d  = mem_sat_q;
        if (push) begin
            for (int k = 0; k < 3; k++) begin
                mem_data_d[wr_ptr_q][k] = rq_data[k];
            end
            mem_sat_d[wr_ptr_q] = rq_sat;
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q ^ push;
        rd_ptr_d    = rd_ptr_q ^ pop;
        count_d     = count_q;
        phase_d     = phase_q;
        sat_count_d = sat_count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        if (out_xfer) begin
            case (phase_q)
                EMIT0:   phase_d = EMIT1;
                EMIT1:   phase_d = EMIT2;
                EMIT2:   phase_d = EMIT0;
                default: phase_d = EMIT0;
            endcase
            if (out_sat && (sat_count_q != 16'hFFFF)) begin
                sat_count_d = sat_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q     <= 2'd0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            phase_q     <= EMIT0;
            sat_count_q <= 16'd0;
        end else begin
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            phase_q     <= phase_d;
            sat_count_q <= sat_count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_data_q <= mem_data_d;
        mem_sat_q  <= mem_sat_d;
    end

endmodule

// File: tb/tb_fir_par3_serializer.sv
// tb/tb_fir_par3_serializer.sv - scoreboard bench for the 3-phase FIR serializer
module tb_fir_par3_serializer;

    typedef struct packed {
        logic [15:0] d;
        logic        s;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [63:0] in_p0, in_p1, in_p2;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               out_sat;
    logic [15:0]        sat_count;

    int   n_vec  = 0;
    int   n_miss = 0;
    exp_t sbq[$];
    logic [15:0] exp_sc = 16'd0;
    int   cyc = 0;
    int   xfer_cnt = 0;
    int   first_cyc = 0;
    int   last_cyc = 0;
    bit   arm_first = 1'b0;

    fir_par3_serializer #(.IN_W(64), .OUT_W(16), .SHIFT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_p0     (in_p0),
        .in_p1     (in_p1),
        .in_p2     (in_p2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic signed [63:0] x);
        logic signed [127:0] v;
        exp_t r;
        v = x;
        v = (v + 128'sd16384) >>> 15;
        if (v > 128'sd32767) begin
            r.d = 16'h7FFF; r.s = 1'b1;
        end else if (v < -128'sd32768) begin
            r.d = 16'h8000; r.s = 1'b1;
        end else begin
            r.d = v[15:0]; r.s = 1'b0;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sbq.delete();
            exp_sc = 16'd0;
        end else begin
            cyc++;
            if (out_valid && out_ready) begin
                n_vec++;
                if (sbq.size() == 0) begin
                    n_miss++;
                    $display("FAIL unexpected_output got=%0d sat=%0b required=none", out_data, out_sat);
                end else begin
                    e = sbq.pop_front();
                    if ({out_data, out_sat} !== {e.d, e.s}) begin
                        n_miss++;
                        $display("FAIL sample got=%0d/%0b required=%0d/%0b", out_data, out_sat, $signed(e.d), e.s);
                    end
                    if (e.s && exp_sc != 16'hFFFF) exp_sc++;
                end
                xfer_cnt++;
                if (arm_first) begin
                    first_cyc = cyc;
                    arm_first = 1'b0;
                end
                last_cyc = cyc;
            end
            if (in_valid && in_ready) begin
                sbq.push_back(model(in_p0));
                sbq.push_back(model(in_p1));
                sbq.push_back(model(in_p2));
            end
        end
    end

    task automatic wait_accept(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL %s accept_timeout got=in_ready_low required=accept", name);
        end
    endtask

    task automatic send_triple(input logic signed [63:0] a, b, c, input string name);
        in_p0 = a; in_p1 = b; in_p2 = c;
        in_valid = 1'b1;
        wait_accept(name);
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (!out_valid && sbq.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL %s drain_timeout got=pending=%0d required=0", name, sbq.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_p0 = 64'sd32768; in_p1 = 64'sd32768; in_p2 = 64'sd32768;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_vec++;
        if ({in_ready, out_valid, out_data, out_sat, sat_count} !== {1'b1, 1'b0, 16'd0, 1'b0, 16'd0}) begin
            n_miss++;
            $display("FAIL reset_state got=%b/%b/%0d/%b/%0d required=1/0/0/0/0",
                     in_ready, out_valid, out_data, out_sat, sat_count);
        end
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL reset_ignores_in_valid got=%b required=0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send_triple(64'sd32768, 64'sd49152, -64'sd16384, "basic");
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'sd1) begin
            n_miss++;
            $display("FAIL basic_latency got=%b/%0d required=1/1", out_valid, out_data);
        end
        drain("basic");
    endtask

    task automatic test_saturation();
        logic [15:0] base;
        base = sat_count;
        send_triple(64'sh100_0000_0000, -64'sh100_0000_0000, 64'sd16383, "sat");
        in_valid = 1'b0;
        drain("sat");
        n_vec++;
        if (sat_count !== base + 16'd2 || sat_count !== exp_sc) begin
            n_miss++;
            $display("FAIL sat_count got=%0d required=%0d", sat_count, base + 16'd2);
        end
    endtask

    task automatic test_fill();
        out_ready = 1'b0;
        send_triple(64'sd163840, 64'sd196608, 64'sd229376, "fill_a");
        send_triple(-64'sd163840, -64'sd196608, -64'sd229376, "fill_b");
        in_p0 = 64'sd32768; in_p1 = 64'sd65536; in_p2 = 64'sd98304;
        in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            n_vec++;
            if ({in_ready, out_valid, out_data} !== {1'b0, 1'b1, 16'sd5}) begin
                n_miss++;
                $display("FAIL fill_hold got=%b/%b/%0d required=0/1/5", in_ready, out_valid, out_data);
            end
        end
        out_ready = 1'b1;
        wait_accept("fill_c");
        in_valid = 1'b0;
        drain("fill");
    endtask

    task automatic test_back_to_back();
        int base;
        out_ready = 1'b1;
        base = xfer_cnt;
        arm_first = 1'b1;
        for (int t = 0; t < 100; t++) begin
            logic signed [63:0] v [3];
            for (int k = 0; k < 3; k++) begin
                v[k] = $signed({$urandom, $urandom}) >>> $urandom_range(20, 40);
            end
            send_triple(v[0], v[1], v[2], "b2b");
        end
        in_valid = 1'b0;
        drain("b2b");
        n_vec++;
        if (xfer_cnt - base !== 300 || last_cyc - first_cyc !== 299) begin
            n_miss++;
            $display("FAIL b2b_throughput got=%0d_samples_in_%0d_cycles required=300_in_300",
                     xfer_cnt - base, last_cyc - first_cyc + 1);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        bit ok = 1'b0;
        out_ready = 1'b1;
        base = xfer_cnt;
        send_triple(64'sh100_0000_0000, 64'sh100_0000_0000, 64'sh100_0000_0000, "mid");
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (xfer_cnt - base >= 2) begin ok = 1'b1; break; end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL mid_wait got=%0d required=2", xfer_cnt - base);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({out_valid, in_ready, sat_count} !== {1'b0, 1'b1, 16'd0}) begin
            n_miss++;
            $display("FAIL mid_reset got=%b/%b/%0d required=0/1/0", out_valid, in_ready, sat_count);
        end
        @(posedge clk);
        #1;
        send_triple(64'sd98304, 64'sd131072, 64'sd163840, "mid_after");
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 16'sd3) begin
            n_miss++;
            $display("FAIL mid_restart got=%b/%0d required=1/3", out_valid, out_data);
        end
        drain("mid_after");
    endtask

    task automatic test_sat_count_limit();
        out_ready = 1'b1;
        for (int t = 0; t < 21847; t++) begin
            send_triple(64'sh100_0000_0000, -64'sh100_0000_0000, 64'sh7FFF_FFFF_FFFF_FFFF, "satlim");
        end
        in_valid = 1'b0;
        drain("satlim");
        n_vec++;
        if (sat_count !== 16'hFFFF || exp_sc !== 16'hFFFF) begin
            n_miss++;
            $display("FAIL sat_count_limit got=%h required=ffff", sat_count);
        end
    endtask

    initial begin
        in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
        in_p0 = '0; in_p1 = '0; in_p2 = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_fill();
        test_back_to_back();
        test_reset_mid();
        test_sat_count_limit();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
